// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard sources in, pipeline enables and debug counters out.
// The pipeline side is master and the hazard controller is slave.
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             ext_stall;
    logic [REG_W-1:0] IFID_Rs;
    logic [REG_W-1:0] IFID_Rt;
    logic             ID_UsesRt;
    logic             ID_IsBranch;
    logic             ID_BranchTaken;
    logic             ID_IsJump;
    logic             ID_IsJr;
    logic             IDEX_MemRead;
    logic             IDEX_RegWrite;
    logic [REG_W-1:0] IDEX_WriteReg;
    logic             EXMEM_MemRead;
    logic [REG_W-1:0] EXMEM_WriteReg;
    logic             PC_Write;
    logic             IFID_Write;
    logic             IF_flush;
    logic             IDEX_flush;
    logic             stall_busy;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ext_stall, IFID_Rs, IFID_Rt, ID_UsesRt, ID_IsBranch, ID_BranchTaken,
               ID_IsJump, ID_IsJr, IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
               EXMEM_MemRead, EXMEM_WriteReg,
        input  PC_Write, IFID_Write, IF_flush, IDEX_flush, stall_busy,
               stall_count, flush_count
    );

    modport slave (
        input  ext_stall, IFID_Rs, IFID_Rt, ID_UsesRt, ID_IsBranch, ID_BranchTaken,
               ID_IsJump, ID_IsJr, IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
               EXMEM_MemRead, EXMEM_WriteReg,
        output PC_Write, IFID_Write, IF_flush, IDEX_flush, stall_busy,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central hazard controller for the 5-stage MIPS pipeline: load-use / ID-operand stalls,
// wrong-path flush on taken branches and jumps, saturating stall/flush debug counters.
module hazard_stall_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_stall_ctrl_if.slave bus
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [0:0]       state;
    logic             rem;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic id_reads_rt;
    logic id_cmp;
    logic dep_ex;
    logic dep_mem;
    logic need2;
    logic need1;
    logic stall_now;
    logic flush_now;

    function automatic logic reg_match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] y);
        return (x == y) && (y != '0);
    endfunction

    always_comb begin
        id_reads_rt = bus.ID_UsesRt || bus.ID_IsBranch;
        id_cmp      = bus.ID_IsBranch || bus.ID_IsJr;
        dep_ex      = reg_match(bus.IFID_Rs, bus.IDEX_WriteReg) ||
                      (id_reads_rt && reg_match(bus.IFID_Rt, bus.IDEX_WriteReg));
        dep_mem     = reg_match(bus.IFID_Rs, bus.EXMEM_WriteReg) ||
                      (id_reads_rt && reg_match(bus.IFID_Rt, bus.EXMEM_WriteReg));
        need2       = 1'b0;
        need1       = 1'b0;
        if (state == ST_RUN) begin
            if (id_cmp && bus.IDEX_MemRead && dep_ex)
                need2 = 1'b1;
            else if (id_cmp && bus.IDEX_RegWrite && dep_ex)
                need1 = 1'b1;
            else if (id_cmp && bus.EXMEM_MemRead && dep_mem)
                need1 = 1'b1;
            else if (!id_cmp && bus.IDEX_MemRead && dep_ex)
                need1 = 1'b1;
        end
        stall_now = (state == ST_STALL) || need1 || need2;
        // A stall defers any branch/jump redirect until the operands are ready.
        flush_now = (state == ST_RUN) && !need1 && !need2 &&
                    (bus.ID_IsJump || bus.ID_IsJr || (bus.ID_IsBranch && bus.ID_BranchTaken));
    end

    always_comb begin
        bus.PC_Write   = 1'b0;
        bus.IFID_Write = 1'b0;
        bus.IF_flush   = 1'b0;
        bus.IDEX_flush = 1'b0;
        if (!rst && !bus.ext_stall) begin
            if (stall_now) begin
                bus.IDEX_flush = 1'b1;
            end else if (flush_now) begin
                bus.PC_Write = 1'b1;
                bus.IF_flush = 1'b1;
            end else begin
                bus.PC_Write   = 1'b1;
                bus.IFID_Write = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            rem       <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!bus.ext_stall) begin
            if (state == ST_STALL) begin
                state <= ST_RUN;
                rem   <= 1'b0;
            end else if (need2) begin
                state <= ST_STALL;
                rem   <= 1'b1;
            end
            if (stall_now && stall_cnt != '1)
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (flush_now && flush_cnt != '1)
                flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.stall_busy  = (state == ST_STALL) && rem;
    assign bus.stall_count = stall_cnt;
    assign bus.flush_count = flush_cnt;
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central hazard controller for the 5-stage MIPS pipeline with jal/jr. It sequences the pipeline-register write enables and flushes:
- PC write enable
- IF/ID write enable and IF/ID flush
- ID/EX bubble insertion

It detects load-use and ID-stage operand hazards for branches and jr, and sequences multi-cycle stalls with a small FSM. It flushes the wrong-path fetch on taken branches and jumps, and keeps saturating stall and flush event counters for debug.

Parameters:
REG_W, 5, register specifier width
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
ext_stall  input  1  global freeze (memory not ready); holds everything
IFID_Rs  input  REG_W  rs of the instruction in ID
IFID_Rt  input  REG_W  rt of the instruction in ID
ID_UsesRt  input  1  ID instruction reads rt
ID_IsBranch  input  1  beq/bne in ID (compares operands in ID)
ID_BranchTaken  input  1  branch condition true in ID
ID_IsJump  input  1  j/jal in ID
ID_IsJr  input  1  jr in ID (reads rs in ID)
IDEX_MemRead  input  1  load in EX
IDEX_RegWrite  input  1  EX instruction writes a register
IDEX_WriteReg  input  REG_W  destination of the EX instruction
EXMEM_MemRead  input  1  load in MEM
EXMEM_WriteReg  input  REG_W  destination of the MEM instruction
PC_Write  output  1  PC load enable
IFID_Write  output  1  IF/ID register load enable
IF_flush  output  1  clear IF/ID
IDEX_flush  output  1  insert bubble into ID/EX (zero control bits)
stall_busy  output  1  FSM in STALL state
stall_count  output  CNT_W  cycles stalled, saturating
flush_count  output  CNT_W  IF flushes issued, saturating

Behaviour:
- Dependencies and matches:
  - "match(x,y)" means x==y and y!=0. Register 0 never causes a hazard.
  - dep_EX = match(IFID_Rs, IDEX_WriteReg) or (ID_UsesRt and match(IFID_Rt, IDEX_WriteReg)).
  - dep_MEM is the same as dep_EX, using EXMEM_WriteReg.
  - ID_IsJr and ID_IsBranch count as an rs read. ID_IsBranch also counts as an rt read.
- Required bubbles N, evaluated in RUN only, first hit wins:
  - (ID_IsBranch or ID_IsJr) and IDEX_MemRead and dep_EX -> N=2.
  - (ID_IsBranch or ID_IsJr) and IDEX_RegWrite and dep_EX -> N=1.
  - (ID_IsBranch or ID_IsJr) and EXMEM_MemRead and dep_MEM -> N=1.
  - Other instruction with IDEX_MemRead and dep_EX -> N=1 (load-use).
  - Otherwise N=0.
- FSM states RUN and STALL, plus a 1-bit remaining counter rem:
  - RUN with N>=1: stall this cycle. If N==2, go to STALL with rem=1. Otherwise stay in RUN.
  - STALL: stall this cycle. Hazard inputs are ignored. Return to RUN next cycle (rem 1->0).
- Stall cycle outputs: PC_Write=0, IFID_Write=0, IF_flush=0, IDEX_flush=1.
- Flush cycle: RUN, N==0, and (ID_IsJump or ID_IsJr or (ID_IsBranch and ID_BranchTaken)).
  - Outputs: PC_Write=1, IFID_Write=0, IF_flush=1, IDEX_flush=0.
  - IFID_Write must be 0 on any flush because the IF/ID register gives write priority over flush.
- Normal cycle: PC_Write=1, IFID_Write=1, IF_flush=0, IDEX_flush=0.
- Priority: rst > ext_stall > stall > flush > normal. A stall defers a branch or jump; it is re-evaluated once the stall ends.
- ext_stall=1:
  - PC_Write=0, IFID_Write=0, IF_flush=0, IDEX_flush=0.
  - FSM, rem and counters hold.
  - A pending STALL cycle resumes after ext_stall drops.
- Counters:
  - stall_count increments on each stall cycle (ext_stall excluded). flush_count increments on each flush cycle.
  - Both saturate at all-ones.
- Reset (sampled on clk, rst=1):
  - Next state RUN, rem=0, stall_count=0, flush_count=0, stall_busy=0.
  - While rst=1, outputs are PC_Write=0, IFID_Write=0, IF_flush=0, IDEX_flush=0.
  - Reset mid-STALL aborts the stall. The first cycle after reset is RUN.
- Outputs are combinational from state and current inputs, giving 0-cycle latency to the pipeline enables. The counters and stall_busy are registered.

Test Plan:
1. Load-use: lw $2 in EX (IDEX_MemRead=1, IDEX_WriteReg=2); add reading IFID_Rs=2 -> one cycle of PC_Write=0, IFID_Write=0, IDEX_flush=1; then normal; stall_count=1.
2. jr after load: IDEX_MemRead=1, WriteReg=31, ID_IsJr=1, IFID_Rs=31 -> two stall cycles (stall_busy=1 in the 2nd). Next cycle, with no hazard, is a flush: IF_flush=1, IFID_Write=0, PC_Write=1; flush_count=1.
3. Branch after ALU op: IDEX_RegWrite=1, WriteReg=5, beq with Rt=5 and taken -> one stall cycle, then flush cycle; branch with IFID_Rs=0 and WriteReg=0 -> no stall.
4. ext_stall asserted in the middle of an N=2 sequence for 3 cycles -> all four enables 0, stall_count frozen; after release one more stall cycle, then RUN.
5. rst asserted during STALL -> next cycle RUN, counters 0. Drive counters to saturation with CNT_W=4 -> holds at 15.
